// File: rtl/aes_block_serializer.sv
// Buffers finished AES ciphertext blocks in a small FIFO and returns them to the
// host one OUT_W-bit chunk per request, using the req/ready unloading handshake.
module aes_block_serializer #(
    parameter int unsigned BLOCK_W   = 128,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pi_block_valid,
    input  logic [BLOCK_W-1:0]         pi_block,
    output logic                       po_block_ready,
    input  logic                       pi_flush,
    input  logic                       pi_next_val_req,
    output logic                       po_next_val_ready,
    output logic [OUT_W-1:0]           po_data,
    output logic                       po_last,
    output logic [$clog2(DEPTH+1)-1:0] po_count,
    output logic                       po_overflow
);

    localparam int unsigned N  = BLOCK_W / OUT_W;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [BLOCK_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [KW-1:0]      r_k;
    logic               r_pending;
    logic               r_overflow;
    logic               r_ready;
    logic               r_last;
    logic [OUT_W-1:0]   r_data;

    logic               w_full;
    logic               w_push;
    logic               w_serve;
    logic               w_pop;
    logic               w_k_last;
    int unsigned        w_shift;
    logic [BLOCK_W-1:0] w_shifted;
    logic [OUT_W-1:0]   w_chunk;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_push   = pi_block_valid && !w_full && !pi_flush;
    // A stored pending request and a fresh one are served by the same edge.
    assign w_serve  = (pi_next_val_req || r_pending) && (r_count != '0) && !pi_flush;
    assign w_k_last = (r_k == KW'(N - 1));
    assign w_pop    = w_serve && w_k_last;

    always_comb begin
        w_shift = '0;
        if (MSB_FIRST)
            w_shift = (N - 1 - 32'(r_k)) * OUT_W;
        else
            w_shift = 32'(r_k) * OUT_W;
        w_shifted = r_mem[r_rd_ptr] >> w_shift;
        w_chunk   = w_shifted[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= pi_block;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_k        <= '0;
            r_pending  <= 1'b0;
            r_overflow <= 1'b0;
            r_ready    <= 1'b0;
            r_last     <= 1'b0;
            r_data     <= '0;
        end else if (pi_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_k        <= '0;
            r_pending  <= 1'b0;
            r_overflow <= 1'b0;
            r_ready    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (pi_block_valid && w_full)
                r_overflow <= 1'b1;

            r_ready <= w_serve;
            r_last  <= w_serve && w_k_last;
            if (w_serve) begin
                r_data <= w_chunk;
                r_k    <= w_k_last ? '0 : r_k + KW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_serve)
                r_pending <= 1'b0;
            else if (pi_next_val_req && (r_count == '0))
                r_pending <= 1'b1;
        end
    end

    // Gated by rst_n so the flag reads 0 during reset and 1 as soon as it lifts.
    assign po_block_ready    = rst_n && !w_full;
    assign po_next_val_ready = r_ready;
    assign po_data           = r_data;
    assign po_last           = r_last;
    assign po_count          = r_count;
    assign po_overflow       = r_overflow;

endmodule

// File: tb/tb_aes_block_serializer.sv
// Self-checking bench: three serializer configurations share block/flush/reset stimulus,
// expected chunks are queued when requests are driven and compared as pulses appear.
module tb_aes_block_serializer;

    localparam logic [127:0] BLK = 128'h00112233445566778899AABBCCDDEEFF;

    typedef struct {
        logic [7:0] msb;
        logic [7:0] lsb;
        logic       last;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [127:0] blk;
    logic         flush;
    logic         req8, reqlsb, req32;

    logic         m_rb, m_rdy, m_last, m_ovf;
    logic [7:0]   m_data;
    logic [2:0]   m_count;
    logic         l_rb, l_rdy, l_last, l_ovf;
    logic [7:0]   l_data;
    logic [2:0]   l_count;
    logic         w_rb, w_rdy, w_last, w_ovf;
    logic [31:0]  w_data;
    logic [2:0]   w_count;

    int errors = 0;
    int checks = 0;
    int pulses8 = 0;

    logic [8:0]  q8[$];
    logic [8:0]  qlsb[$];
    logic [32:0] q32[$];

    always #5 clk = ~clk;

    aes_block_serializer #(.BLOCK_W(128), .OUT_W(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_main (
        .clk(clk), .rst_n(rst_n), .pi_block_valid(valid), .pi_block(blk),
        .po_block_ready(m_rb), .pi_flush(flush), .pi_next_val_req(req8),
        .po_next_val_ready(m_rdy), .po_data(m_data), .po_last(m_last),
        .po_count(m_count), .po_overflow(m_ovf));

    aes_block_serializer #(.BLOCK_W(128), .OUT_W(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .pi_block_valid(valid), .pi_block(blk),
        .po_block_ready(l_rb), .pi_flush(flush), .pi_next_val_req(reqlsb),
        .po_next_val_ready(l_rdy), .po_data(l_data), .po_last(l_last),
        .po_count(l_count), .po_overflow(l_ovf));

    aes_block_serializer #(.BLOCK_W(128), .OUT_W(32), .DEPTH(4), .MSB_FIRST(1'b1)) u_w32 (
        .clk(clk), .rst_n(rst_n), .pi_block_valid(valid), .pi_block(blk),
        .po_block_ready(w_rb), .pi_flush(flush), .pi_next_val_req(req32),
        .po_next_val_ready(w_rdy), .po_data(w_data), .po_last(w_last),
        .po_count(w_count), .po_overflow(w_ovf));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q8.size() + qlsb.size() + q32.size()) != 0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if ((q8.size() + qlsb.size() + q32.size()) != 0) begin
            errors++;
            $display("FAIL %s: got %0d chunks outstanding, expected 0",
                     name, q8.size() + qlsb.size() + q32.size());
        end
    endtask

    always @(negedge clk) begin
        if (m_rdy) begin
            pulses8++;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_unexpected_pulse: got data=%0h last=%0b, expected no pulse", m_data, m_last);
            end else begin
                chk("main_chunk", 64'({m_last, m_data}), 64'(q8.pop_front()));
            end
        end
        if (l_rdy) begin
            if (qlsb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lsb_unexpected_pulse: got data=%0h, expected no pulse", l_data);
            end else begin
                chk("lsb_chunk", 64'({l_last, l_data}), 64'(qlsb.pop_front()));
            end
        end
        if (w_rdy) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w32_unexpected_pulse: got data=%0h, expected no pulse", w_data);
            end else begin
                chk("w32_chunk", 64'({w_last, w_data}), 64'(q32.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[16];
        logic [31:0] t32[4];
        int          p0;

        for (int i = 0; i < 16; i++) begin
            tbl[i].msb  = 8'(i * 17);
            tbl[i].lsb  = 8'((15 - i) * 17);
            tbl[i].last = (i == 15);
        end
        t32[0] = 32'h00112233;
        t32[1] = 32'h44556677;
        t32[2] = 32'h8899AABB;
        t32[3] = 32'hCCDDEEFF;

        rst_n = 1'b0; valid = 1'b0; blk = '0; flush = 1'b0;
        req8 = 1'b0; reqlsb = 1'b0; req32 = 1'b0;
        #1;
        chk("reset_count", 64'(m_count), 64'(0));
        chk("reset_block_ready", 64'(m_rb), 64'(0));
        chk("reset_rdy", 64'(m_rdy), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("post_reset_block_ready", 64'(m_rb), 64'(1));
        chk("post_reset_overflow", 64'(m_ovf), 64'(0));

        // Order: one block into all three configurations, then the chunk table
        valid = 1'b1; blk = BLK;
        tick();
        valid = 1'b0;
        chk("order_count_after_push", 64'(m_count), 64'(1));
        chk("w32_count_after_push", 64'(w_count), 64'(1));
        for (int i = 0; i < 16; i++) begin
            req8 = 1'b1; reqlsb = 1'b1; req32 = (i < 4);
            q8.push_back({tbl[i].last, tbl[i].msb});
            qlsb.push_back({tbl[i].last, tbl[i].lsb});
            if (i < 4) q32.push_back({(i == 3), t32[i]});
            if (i == 15) chk("order_count_before_last", 64'(m_count), 64'(1));
            tick();
        end
        req8 = 1'b0; reqlsb = 1'b0; req32 = 1'b0;
        chk("order_count_after_last", 64'(m_count), 64'(0));
        chk("lsb_count_after_last", 64'(l_count), 64'(0));
        chk("w32_count_after_4", 64'(w_count), 64'(0));
        drain("order_drain");

        // Full and overflow
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; blk = {16{8'(8'hA0 + i)}};
            tick();
            if (i == 2) chk("full_ready_at_3", 64'(m_rb), 64'(1));
            if (i == 3) chk("full_ready_at_4", 64'(m_rb), 64'(0));
        end
        valid = 1'b0;
        chk("full_count", 64'(m_count), 64'(4));
        chk("full_overflow", 64'(m_ovf), 64'(1));
        for (int i = 0; i < 16; i++) begin
            req8 = 1'b1;
            q8.push_back({(i == 15), 8'hA0});
            tick();
        end
        req8 = 1'b0;
        chk("full_count_after_read", 64'(m_count), 64'(3));
        chk("full_ready_after_read", 64'(m_rb), 64'(1));
        chk("full_overflow_sticky", 64'(m_ovf), 64'(1));
        drain("full_drain");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_count", 64'(m_count), 64'(0));
        chk("flush_overflow", 64'(m_ovf), 64'(0));

        // Pending request on an empty FIFO
        p0 = pulses8;
        req8 = 1'b1; tick(); req8 = 1'b0;
        tick(); tick();
        req8 = 1'b1; tick(); req8 = 1'b0;
        tick();
        chk("pending_no_early_pulse", 64'(pulses8 - p0), 64'(0));
        valid = 1'b1; blk = BLK;
        q8.push_back({1'b0, 8'h00});
        tick();
        valid = 1'b0;
        chk("pending_c1_idle", 64'(m_rdy), 64'(0));
        tick();
        chk("pending_c2_rdy", 64'(m_rdy), 64'(1));
        chk("pending_c2_data", 64'(m_data), 64'(8'h00));
        repeat (4) tick();
        chk("pending_single_pulse", 64'(pulses8 - p0), 64'(1));
        chk("pending_count", 64'(m_count), 64'(1));
        flush = 1'b1; tick(); flush = 1'b0;

        // Asynchronous reset mid-block
        valid = 1'b1; blk = BLK; tick(); valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req8 = 1'b1;
            q8.push_back({1'b0, tbl[i].msb});
            tick();
        end
        req8 = 1'b0;
        drain("reset_mid_drain");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(m_count), 64'(0));
        chk("arst_data", 64'(m_data), 64'(0));
        chk("arst_last", 64'(m_last), 64'(0));
        chk("arst_block_ready", 64'(m_rb), 64'(0));
        tick();
        rst_n = 1'b1;
        #1;
        chk("arst_release_ready", 64'(m_rb), 64'(1));
        valid = 1'b1; blk = BLK; tick(); valid = 1'b0;
        req8 = 1'b1; q8.push_back({1'b0, 8'h00}); tick(); req8 = 1'b0;
        drain("arst_restart_drain");
        flush = 1'b1; tick(); flush = 1'b0;

        // Flush mid-block with overflow set and a competing push/request
        valid = 1'b1; blk = BLK; tick();
        for (int i = 1; i < 5; i++) begin
            blk = {16{8'(8'hC0 + i)}};
            tick();
        end
        valid = 1'b0;
        chk("flush_pre_overflow", 64'(m_ovf), 64'(1));
        for (int i = 0; i < 5; i++) begin
            req8 = 1'b1;
            q8.push_back({1'b0, tbl[i].msb});
            tick();
        end
        req8 = 1'b0;
        drain("flush_mid_drain");
        flush = 1'b1; valid = 1'b1; req8 = 1'b1; blk = BLK;
        tick();
        flush = 1'b0; valid = 1'b0; req8 = 1'b0;
        chk("flushmid_count", 64'(m_count), 64'(0));
        chk("flushmid_overflow", 64'(m_ovf), 64'(0));
        chk("flushmid_rdy", 64'(m_rdy), 64'(0));
        chk("flushmid_data_held", 64'(m_data), 64'(8'h44));
        tick();
        valid = 1'b1; blk = BLK; tick(); valid = 1'b0;
        req8 = 1'b1; q8.push_back({1'b0, 8'h00}); tick(); req8 = 1'b0;
        drain("flush_restart_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_block_serializer.md
Name: aes_block_serializer

Overview:
- Buffers finished 128-bit AES ciphertext blocks from the encryption core and returns them to the host in OUT_W-bit chunks.
- Uses the same pi_next_val_req / po_next_val_ready request–response handshake as the existing loading path.
- Generalises the fixed single-block, byte-wide unloading with three additions: a DEPTH-block FIFO, a configurable chunk width and chunk order, and a pending-request mechanism.

Parameters:
- BLOCK_W, 128, ciphertext block width in bits; must be a multiple of OUT_W.
- OUT_W, 8, output chunk width (8/16/32/64); N = BLOCK_W/OUT_W chunks per block.
- DEPTH, 4, FIFO capacity in blocks; power of 2, at least 2.
- MSB_FIRST, 1, 1 = chunk 0 is bits [BLOCK_W-1 -: OUT_W]; 0 = chunk 0 is bits [OUT_W-1:0].

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pi_block_valid  in  1  ciphertext block offered (typically the core's enc_done).
- pi_block  in  BLOCK_W  ciphertext block.
- po_block_ready  out  1  FIFO can accept a block.
- pi_flush  in  1  synchronous clear of buffer and handshake state.
- pi_next_val_req  in  1  host request for the next chunk.
- po_next_val_ready  out  1  one-cycle pulse; po_data is valid.
- po_data  out  OUT_W  current chunk; holds its value between pulses.
- po_last  out  1  high with po_next_val_ready on chunk N-1 of a block.
- po_count  out  $clog2(DEPTH+1)  number of blocks stored, including a partially read one.
- po_overflow  out  1  sticky flag: a block was offered while the FIFO was full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0 immediately; po_block_ready is 1 once rst_n is deasserted.
  - FIFO pointers, chunk index, pending flag and overflow are cleared.
  - Reset asserted mid-block discards everything; there is no partial resume.
- Write:
  - A push occurs when pi_block_valid and po_block_ready are both high.
  - po_block_ready = (po_count < DEPTH), computed from registered state; there is no same-cycle bypass from a pop.
  - pi_block_valid while full: the block is dropped, po_overflow is set, po_count is unchanged.
- Read:
  - Chunk index k runs 0..N-1 and addresses the head block.
  - pi_next_val_req sampled high with po_count > 0 at a rising edge → in the next cycle po_next_val_ready = 1, po_data = chunk k, po_last = (k == N-1). k then increments.
  - When k == N-1 is served, the head block is popped, po_count decrements and k returns to 0.
  - Back-to-back requests are allowed: one chunk per cycle, continuing across block boundaries without a gap.
- Pending request:
  - A request sampled while po_count == 0 sets the pending flag.
  - The flag is served at the first edge where po_count > 0.
  - Timing example: valid in cycle c with an empty FIFO and the flag set gives ready in cycle c+2.
  - Further requests while pending are absorbed; at most one request is ever pending.
- Simultaneous push and pop in one cycle: both happen and po_count is unchanged. When full, the push is still refused (ready is registered).
- Flush (pi_flush high at an edge):
  - Clears FIFO, k, pending flag and po_overflow; po_count becomes 0.
  - Has priority over a push or request in the same cycle; po_next_val_ready is 0 in the following cycle.
  - po_data keeps its last value.
- Pointers wrap modulo DEPTH.

Test Plan:
- Order, MSB first: OUT_W=8, MSB_FIRST=1, push 0x00112233445566778899AABBCCDDEEFF, then 16 requests, one per cycle → 16 consecutive ready pulses with data 00,11,22…FF; po_last only on FF; po_count goes 1→0 after the 16th.
- Order, LSB first and wider chunks:
  - MSB_FIRST=0 with the same block → first chunk FF, last chunk 00.
  - OUT_W=32, MSB_FIRST=1 → 00112233, 44556677, 8899AABB, CCDDEEFF, with po_last on the 4th.
- Full and overflow: DEPTH=4, push 5 blocks on consecutive cycles → po_block_ready low after the 4th, 5th dropped, po_count=4, po_overflow=1. Reading 16 chunks then shows count=3 and ready high.
- Pending: request on an empty FIFO; push a block in cycle c → single ready pulse in cycle c+2 with chunk 00; a second request during the pending wait does not cause an extra pulse.
- Reset and flush mid-block:
  - Read 5 chunks, pull rst_n low asynchronously → outputs 0 immediately; a new block then starts at chunk 0.
  - Repeat with pi_flush instead of reset → po_count=0 and po_overflow=0.
